// File: rtl/seq_mult32.sv
// Iterative shift-add unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH product over WIDTH cycles.
// Start/busy/done handshake; product is a held register updated only on completion.
module seq_mult32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplr;
    logic [WIDTH:0]    acc;
    logic [WIDTH:0]    sum;
    logic [CW-1:0]     count;
    logic              accept;

    // Partial-product add; the carry lands in sum[WIDTH] and is shifted down, never lost.
    always_comb begin
        sum = {1'b0, acc[WIDTH-1:0]} + (mplr[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    end

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= {1'b0, sum[WIDTH:1]};
                    mplr  <= {sum[0], mplr[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        product <= {sum, mplr[WIDTH-1:1]};
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= accept ? RUN : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Operand load is shared by the IDLE and DONE accept paths.
            if (accept) begin
                mcand <= a;
                mplr  <= b;
                acc   <= '0;
                count <= '0;
            end
        end
    end

endmodule
